// File: rtl/reg_file_multiport.sv
// Two-write / two-read register file with per-register busy (scoreboard) bits.
// Write port 2 has priority over write port 1 on the same register. A reserve
// request marks a register busy until a later write to it clears the bit. An
// optional hardwired-zero register 0 and optional same-cycle write forwarding
// to the read ports are selected by parameters.
module reg_file_multiport #(
  parameter int WIDTH     = 8,
  parameter int ADDR_BITS = 3,
  parameter int ZERO_REG  = 0,
  parameter int BYPASS    = 0
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [WIDTH-1:0]     WRITEDATA1,
  input  logic [WIDTH-1:0]     WRITEDATA2,
  input  logic [ADDR_BITS-1:0] WRITEREG1,
  input  logic [ADDR_BITS-1:0] WRITEREG2,
  input  logic                 WRITEENABLE1,
  input  logic                 WRITEENABLE2,
  input  logic [ADDR_BITS-1:0] READREG1,
  input  logic [ADDR_BITS-1:0] READREG2,
  output logic [WIDTH-1:0]     REGOUT1,
  output logic [WIDTH-1:0]     REGOUT2,
  input  logic                 RESERVE,
  input  logic [ADDR_BITS-1:0] RESERVEREG,
  output logic                 BUSY1,
  output logic                 BUSY2
);

  localparam int NREG = 2 ** ADDR_BITS;

  logic [WIDTH-1:0] regs_q [NREG];
  logic [WIDTH-1:0] regs_d [NREG];
  logic [NREG-1:0]  busy_q;
  logic [NREG-1:0]  busy_d;

  // Next state: port 2 overrides port 1, reserve overrides the write's busy clear.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    for (int i = 0; i < NREG; i++) begin
      if (WRITEENABLE2 && (WRITEREG2 == ADDR_BITS'(i))) begin
        regs_d[i] = WRITEDATA2;
      end else if (WRITEENABLE1 && (WRITEREG1 == ADDR_BITS'(i))) begin
        regs_d[i] = WRITEDATA1;
      end
      if ((WRITEENABLE1 && (WRITEREG1 == ADDR_BITS'(i))) ||
          (WRITEENABLE2 && (WRITEREG2 == ADDR_BITS'(i)))) begin
        busy_d[i] = 1'b0;
      end
      if (RESERVE && (RESERVEREG == ADDR_BITS'(i))) begin
        busy_d[i] = 1'b1;
      end
    end
    // A hardwired-zero register never holds data and never becomes busy.
    if (ZERO_REG != 0) begin
      regs_d[0] = '0;
      busy_d[0] = 1'b0;
    end
  end

  // State registers; reset clears everything without waiting for a clock edge.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  // Read port 1: stored value, optionally forwarded write data, forced 0 in reset.
  always_comb begin
    REGOUT1 = regs_q[READREG1];
    if (BYPASS != 0) begin
      if (WRITEENABLE2 && (WRITEREG2 == READREG1)) begin
        REGOUT1 = WRITEDATA2;
      end else if (WRITEENABLE1 && (WRITEREG1 == READREG1)) begin
        REGOUT1 = WRITEDATA1;
      end
    end
    if ((ZERO_REG != 0) && (READREG1 == '0)) begin
      REGOUT1 = '0;
    end
    BUSY1 = busy_q[READREG1];
    if (RESET) begin
      REGOUT1 = '0;
      BUSY1   = 1'b0;
    end
  end

  // Read port 2: same rules as read port 1.
  always_comb begin
    REGOUT2 = regs_q[READREG2];
    if (BYPASS != 0) begin
      if (WRITEENABLE2 && (WRITEREG2 == READREG2)) begin
        REGOUT2 = WRITEDATA2;
      end else if (WRITEENABLE1 && (WRITEREG1 == READREG2)) begin
        REGOUT2 = WRITEDATA1;
      end
    end
    if ((ZERO_REG != 0) && (READREG2 == '0)) begin
      REGOUT2 = '0;
    end
    BUSY2 = busy_q[READREG2];
    if (RESET) begin
      REGOUT2 = '0;
      BUSY2   = 1'b0;
    end
  end

endmodule

// File: tb/tb_reg_file_multiport.sv
// Bench for reg_file_multiport. Two instances share all inputs: instance a is
// plain (no zero register, no forwarding), instance b has both options on.
module tb_reg_file_multiport;

  localparam int W  = 8;
  localparam int AB = 3;
  localparam int N  = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [W-1:0]  wd1, wd2;
  logic [AB-1:0] wr1, wr2, rr1, rr2, resreg;
  logic          we1, we2, res;
  logic [W-1:0]  out1_a, out2_a, out1_b, out2_b;
  logic          busy1_a, busy2_a, busy1_b, busy2_b;

  reg_file_multiport #(.WIDTH(W), .ADDR_BITS(AB), .ZERO_REG(0), .BYPASS(0)) dut_a (
    .CLK(clk), .RESET(rst),
    .WRITEDATA1(wd1), .WRITEDATA2(wd2), .WRITEREG1(wr1), .WRITEREG2(wr2),
    .WRITEENABLE1(we1), .WRITEENABLE2(we2), .READREG1(rr1), .READREG2(rr2),
    .REGOUT1(out1_a), .REGOUT2(out2_a), .RESERVE(res), .RESERVEREG(resreg),
    .BUSY1(busy1_a), .BUSY2(busy2_a)
  );

  reg_file_multiport #(.WIDTH(W), .ADDR_BITS(AB), .ZERO_REG(1), .BYPASS(1)) dut_b (
    .CLK(clk), .RESET(rst),
    .WRITEDATA1(wd1), .WRITEDATA2(wd2), .WRITEREG1(wr1), .WRITEREG2(wr2),
    .WRITEENABLE1(we1), .WRITEENABLE2(we2), .READREG1(rr1), .READREG2(rr2),
    .REGOUT1(out1_b), .REGOUT2(out2_b), .RESERVE(res), .RESERVEREG(resreg),
    .BUSY1(busy1_b), .BUSY2(busy2_b)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Index 0 models instance a, index 1 models instance b.
  int mem [2][N];
  bit bsy [2][N];
  bit zr  [2] = '{1'b0, 1'b1};
  bit byp [2] = '{1'b0, 1'b1};

  task automatic model_reset();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < N; i++) begin
        mem[k][i] = 0;
        bsy[k][i] = 1'b0;
      end
  endtask

  // Effect of one rising edge, applied in the order the rules are stated.
  task automatic model_edge();
    if (rst) return;
    for (int k = 0; k < 2; k++) begin
      if (we1) begin mem[k][wr1] = wd1; bsy[k][wr1] = 1'b0; end
      if (we2) begin mem[k][wr2] = wd2; bsy[k][wr2] = 1'b0; end
      if (res) bsy[k][resreg] = 1'b1;
      if (zr[k]) begin mem[k][0] = 0; bsy[k][0] = 1'b0; end
    end
  endtask

  function automatic int exp_data(int k, int a);
    if (rst) return 0;
    if (zr[k] && a == 0) return 0;
    if (byp[k]) begin
      if (we2 && int'(wr2) == a) return int'(wd2);
      if (we1 && int'(wr1) == a) return int'(wd1);
    end
    return mem[k][a];
  endfunction

  function automatic int exp_busy(int k, int a);
    if (rst) return 0;
    return int'(bsy[k][a]);
  endfunction

  task automatic check_model(input string tag);
    chk({tag, " a.regout1"}, int'(out1_a),  exp_data(0, int'(rr1)));
    chk({tag, " a.regout2"}, int'(out2_a),  exp_data(0, int'(rr2)));
    chk({tag, " a.busy1"},   int'(busy1_a), exp_busy(0, int'(rr1)));
    chk({tag, " a.busy2"},   int'(busy2_a), exp_busy(0, int'(rr2)));
    chk({tag, " b.regout1"}, int'(out1_b),  exp_data(1, int'(rr1)));
    chk({tag, " b.regout2"}, int'(out2_b),  exp_data(1, int'(rr2)));
    chk({tag, " b.busy1"},   int'(busy1_b), exp_busy(1, int'(rr1)));
    chk({tag, " b.busy2"},   int'(busy2_b), exp_busy(1, int'(rr2)));
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input int e1, input int a1, input int d1,
                       input int e2, input int a2, input int d2,
                       input int r, input int ra, input int q1, input int q2);
    we1 = 1'(e1); wr1 = AB'(a1); wd1 = W'(d1);
    we2 = 1'(e2); wr2 = AB'(a2); wd2 = W'(d2);
    res = 1'(r);  resreg = AB'(ra);
    rr1 = AB'(q1); rr2 = AB'(q2);
  endtask

  task automatic clock_edge();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    int e1, a1, d1, e2, a2, d2, r, ra, q1, q2;
    int a_o1, a_b1, a_o2, a_b2;
    int b_o1, b_b1, b_o2, b_b2;
  } vec_t;

  vec_t vecs [10];

  initial begin
    // inputs: we1 wr1 wd1 | we2 wr2 wd2 | res resreg | rr1 rr2 ; expected before the edge:
    //         a: out1 busy1 out2 busy2 | b: out1 busy1 out2 busy2
    vecs[0] = '{0,0,0,  0,0,0,  0,0, 0,5,   0,0,0,0,    0,0,0,0};
    vecs[1] = '{1,3,56, 0,0,0,  0,0, 3,3,   0,0,0,0,    56,0,56,0};
    vecs[2] = '{0,0,0,  0,0,0,  0,0, 3,3,   56,0,56,0,  56,0,56,0};
    vecs[3] = '{1,1,50, 1,1,15, 0,0, 1,2,   0,0,0,0,    15,0,0,0};
    vecs[4] = '{0,0,0,  0,0,0,  1,7, 1,7,   15,0,0,0,   15,0,0,0};
    vecs[5] = '{1,7,40, 0,0,0,  0,0, 7,7,   0,1,0,1,    40,1,40,1};
    vecs[6] = '{0,0,0,  1,4,6,  1,4, 7,4,   40,0,0,0,   40,0,6,0};
    vecs[7] = '{1,0,85, 0,0,0,  0,0, 4,0,   6,1,0,0,    6,1,0,0};
    vecs[8] = '{0,0,0,  0,0,0,  1,0, 0,4,   85,0,6,1,   0,0,6,1};
    vecs[9] = '{0,0,0,  0,0,0,  0,0, 0,3,   85,1,56,0,  0,0,56,0};

    // reset sequence
    rst = 1'b1;
    drive(0,0,0, 0,0,0, 0,0, 0,0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // table-driven directed vectors
    for (int i = 0; i < 10; i++) begin
      string t;
      t = $sformatf("vec%0d", i);
      drive(vecs[i].e1, vecs[i].a1, vecs[i].d1, vecs[i].e2, vecs[i].a2, vecs[i].d2,
            vecs[i].r, vecs[i].ra, vecs[i].q1, vecs[i].q2);
      #1;
      chk({t, " a.regout1"}, int'(out1_a),  vecs[i].a_o1);
      chk({t, " a.busy1"},   int'(busy1_a), vecs[i].a_b1);
      chk({t, " a.regout2"}, int'(out2_a),  vecs[i].a_o2);
      chk({t, " a.busy2"},   int'(busy2_a), vecs[i].a_b2);
      chk({t, " b.regout1"}, int'(out1_b),  vecs[i].b_o1);
      chk({t, " b.busy1"},   int'(busy1_b), vecs[i].b_b1);
      chk({t, " b.regout2"}, int'(out2_b),  vecs[i].b_o2);
      chk({t, " b.busy2"},   int'(busy2_b), vecs[i].b_b2);
      clock_edge();
    end

    // mid-cycle reset: reg3=56, reg7 reserved, write to reg2 set up then dropped
    drive(0,0,0, 0,0,0, 1,7, 3,7);
    clock_edge();
    drive(1,2,99, 0,0,0, 0,0, 3,7);
    #1;
    chk("pre_rst a.regout1", int'(out1_a), 56);
    chk("pre_rst a.busy2",   int'(busy2_a), 1);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("in_rst a.regout1", int'(out1_a), 0);
    chk("in_rst b.regout1", int'(out1_b), 0);
    chk("in_rst a.busy2",   int'(busy2_a), 0);
    chk("in_rst b.busy2",   int'(busy2_b), 0);
    rr1 = AB'(2);
    #1;
    chk("in_rst b.bypass_gated", int'(out1_b), 0);
    clock_edge();
    rst = 1'b0;
    drive(0,0,0, 0,0,0, 0,0, 2,3);
    #1;
    chk("post_rst a.dropped_write", int'(out1_a), 0);
    chk("post_rst a.reg3_cleared",  int'(out2_a), 0);
    // first edge after reset accepts a write
    drive(1,2,99, 0,0,0, 0,0, 2,7);
    clock_edge();
    drive(0,0,0, 0,0,0, 0,0, 2,7);
    #1;
    chk("resume a.regout1", int'(out1_a), 99);
    chk("resume b.regout1", int'(out1_b), 99);
    chk("resume a.busy2",   int'(busy2_a), 0);

    // randomized stimulus against the reference model
    for (int c = 0; c < 400; c++) begin
      bit do_rst;
      drive(($urandom_range(0, 1)), $urandom_range(0, N-1), $urandom_range(0, 255),
            ($urandom_range(0, 1)), $urandom_range(0, N-1), $urandom_range(0, 255),
            ($urandom_range(0, 2) == 0), $urandom_range(0, N-1),
            $urandom_range(0, N-1), $urandom_range(0, N-1));
      // force occasional same-address collisions
      if ($urandom_range(0, 3) == 0) wr2 = wr1;
      if ($urandom_range(0, 3) == 0) rr1 = wr1;
      if ($urandom_range(0, 3) == 0) resreg = wr2;
      do_rst = ($urandom_range(0, 39) == 0);
      #1;
      check_model($sformatf("rand%0d", c));
      if (do_rst) begin
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_model($sformatf("rand%0d_rst", c));
        clock_edge();
        rst = 1'b0;
      end else begin
        clock_edge();
      end
    end

    // ---------------- final report ----------------
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/reg_file_multiport.md
REG_FILE_MULTIPORT -- requirements
Module: reg_file_multiport

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data bits per register.
REQ-002 SHALL have parameter ADDR_BITS, default 3, register address width; the register count is 2**ADDR_BITS.
REQ-003 SHALL have parameter ZERO_REG, default 0; when 1, register 0 is hardwired to zero.
REQ-004 SHALL have parameter BYPASS, default 0; when 1, same-cycle write data is forwarded to read ports.
REQ-005 SHALL have port CLK  in  1  single clock; all state updates occur on its rising edge.
REQ-006 SHALL have port RESET  in  1  reset, asynchronous, active-high.
REQ-007 SHALL have ports WRITEDATA1/WRITEDATA2  in  WIDTH  write data for ports 1 and 2.
REQ-008 SHALL have ports WRITEREG1/WRITEREG2  in  ADDR_BITS  write addresses.
REQ-009 SHALL have ports WRITEENABLE1/WRITEENABLE2  in  1  write strobes.
REQ-010 SHALL have ports READREG1/READREG2  in  ADDR_BITS  read addresses.
REQ-011 SHALL have ports REGOUT1/REGOUT2  out  WIDTH  read data.
REQ-012 SHALL have port RESERVE  in  1  marks register RESERVEREG busy (pending producer).
REQ-013 SHALL have port RESERVEREG  in  ADDR_BITS  register to reserve.
REQ-014 SHALL have ports BUSY1/BUSY2  out  1  busy bit of READREG1/READREG2.

Function
REQ-015 SHALL, on a CLK rising edge with WRITEENABLEn=1 and RESET=0, store WRITEDATAn into register WRITEREGn, visible on reads from the following cycle.
REQ-016 SHALL, when both write ports target the same register in one cycle, store WRITEDATA2 (port 2 priority).
REQ-017 SHALL drive REGOUTn and BUSYn combinationally from READREGn and current state, with no clock latency.
REQ-018 SHALL, with BYPASS=1, return the pending write data for a read of a register being written this cycle (port 2 data if both ports write it); with BYPASS=0, return the stored value.
REQ-019 SHALL keep one busy bit per register: set on an edge with RESERVE=1 for RESERVEREG, cleared on an edge where either write port writes that register.
REQ-020 SHALL, when reserve and write hit the same register on the same edge, leave it busy (reserve wins; the write data is still stored).
REQ-021 SHALL, with ZERO_REG=1, read register 0 as 0, ignore writes to it, never set its busy bit, and exclude it from bypass.
REQ-022 SHALL keep all unaddressed registers and busy bits unchanged every cycle.
REQ-023 SHALL not wrap or truncate addresses; every address value in 0..2**ADDR_BITS-1 is a valid register.

Reset
REQ-024 SHALL, while RESET=1, clear all registers to 0 and all busy bits to 0 immediately, without waiting for CLK.
REQ-025 SHALL drive REGOUT1/REGOUT2=0 and BUSY1/BUSY2=0 for any read address while RESET=1.
REQ-026 SHALL ignore writes and reserves on any edge where RESET=1, including reset asserted mid-cycle after the write was set up.
REQ-027 SHALL resume normal writes on the first rising edge after RESET deasserts.

Verification (WIDTH=8, ADDR_BITS=3)
REQ-028 SHALL cover: reset pulse, then read regs 0 and 5 -> REGOUT1=0, REGOUT2=0, BUSY1=BUSY2=0.
REQ-029 SHALL cover: write1 reg3=56, next cycle READREG1=3 -> 56; same-cycle read with BYPASS=0 -> old value 0, with BYPASS=1 -> 56.
REQ-030 SHALL cover: write1 reg1=50 and write2 reg1=15 on one edge -> reg1 reads 15.
REQ-031 SHALL cover: RESERVE reg7 -> BUSY for reg7=1; write reg7=40 -> BUSY=0 and reads 40; reserve and write reg4=6 on one edge -> reg4=6, BUSY=1.
REQ-032 SHALL cover: ZERO_REG=1, write reg0=85 -> reg0 reads 0; ZERO_REG=0 -> reg0 reads 85.
REQ-033 SHALL cover: RESET asserted between edges with reg3=56 and reg7 busy -> REGOUT=0 immediately, all busy=0, and a write pending at the next edge is dropped.
